// File: rtl/pkt_hdr_capture.sv
// Packet header capture: holds the first flit of each packet and, at end-of-packet,
// emits it as a single-flit header alongside a metadata record for the parser.
package pkt_hdr_capture_pkg;
    typedef struct packed {
        logic [31:0] pktID;
        logic [31:0] flits;
        logic [5:0]  empty;
        logic [55:0] last_7_bytes;
        logic [7:0]  flags;
        logic [15:0] rsvd;
    } metadata_t;
endpackage

module pkt_hdr_capture
    import pkt_hdr_capture_pkg::*;
#(
    parameter int PKT_ID_W = 9,
    parameter int FLIT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] in_pkt_data,
    input  logic         in_pkt_valid,
    output logic         in_pkt_ready,
    input  logic         in_pkt_sop,
    input  logic         in_pkt_eop,
    input  logic [5:0]   in_pkt_empty,
    output logic [511:0] out_pkt_data,
    output logic         out_pkt_valid,
    input  logic         out_pkt_ready,
    output logic         out_pkt_sop,
    output logic         out_pkt_eop,
    output logic [5:0]   out_pkt_empty,
    output metadata_t    out_meta_data,
    output logic         out_meta_valid,
    input  logic         out_meta_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic                ready;

    logic [511:0]        hdr_reg;
    logic [FLIT_W-1:0]   flit_cnt_reg;
    logic [FLIT_W-1:0]   flit_cnt_sat;
    logic [FLIT_W-1:0]   flits_final;
    // Only the low 48 bits of the previous flit can ever reach last_7_bytes
    // (largest window base is 8*63 within the 568-bit {prev56, eop_data} vector).
    logic [47:0]         prev_tail_reg;
    logic [47:0]         prev_tail;
    logic [PKT_ID_W-1:0] pkt_id_reg;
    metadata_t           meta_reg;
    metadata_t           meta_next;
    logic [5:0]          pkt_empty_reg;
    logic                pkt_valid_reg;
    logic                meta_valid_reg;

    logic                accept;
    logic                start;
    logic                body_flit;
    logic                finish;
    logic                pkt_clear;
    logic                meta_clear;
    logic                emit_done;
    logic [559:0]        tail_vec;
    logic [55:0]         last7;

    assign accept     = in_pkt_valid & ready;
    assign start      = accept & in_pkt_sop;
    assign body_flit  = accept & ~in_pkt_sop & (state_reg == BODY);
    assign finish     = (start | body_flit) & in_pkt_eop;
    assign pkt_clear  = ~pkt_valid_reg | out_pkt_ready;
    assign meta_clear = ~meta_valid_reg | out_meta_ready;
    assign emit_done  = (state_reg == EMIT) & pkt_clear & meta_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A sop seen in BODY restarts capture, so it follows the same path as IDLE+sop.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = in_pkt_eop ? EMIT : BODY;
                end
            end
            BODY: begin
                if (accept && in_pkt_eop) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (emit_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        case (state_reg)
            IDLE:    ready = 1'b1;
            BODY:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign flit_cnt_sat = (&flit_cnt_reg) ? flit_cnt_reg : flit_cnt_reg + FLIT_W'(1);
    assign flits_final  = start ? FLIT_W'(1) : flit_cnt_sat;
    assign prev_tail    = start ? 48'd0 : prev_tail_reg;
    assign tail_vec     = {prev_tail, in_pkt_data};

    // Byte gi of last_7_bytes is byte (empty + gi) of the tail vector, counted from the LSB.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_last7
            assign last7[8*gi +: 8] = tail_vec[{1'b0, in_pkt_empty, 3'b000} + 10'(8*gi) +: 8];
        end
    endgenerate

    always_comb begin
        meta_next              = '0;
        meta_next.pktID        = 32'(pkt_id_reg);
        meta_next.flits        = 32'(flits_final);
        meta_next.empty        = in_pkt_empty;
        meta_next.last_7_bytes = last7;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_reg        <= '0;
            flit_cnt_reg   <= '0;
            prev_tail_reg  <= '0;
            pkt_id_reg     <= '0;
            meta_reg       <= '0;
            pkt_empty_reg  <= '0;
            pkt_valid_reg  <= 1'b0;
            meta_valid_reg <= 1'b0;
        end else begin
            if (start) begin
                hdr_reg      <= in_pkt_data;
                flit_cnt_reg <= FLIT_W'(1);
            end else if (body_flit) begin
                flit_cnt_reg <= flit_cnt_sat;
            end

            if (accept) begin
                prev_tail_reg <= in_pkt_data[47:0];
            end

            if (finish) begin
                meta_reg       <= meta_next;
                pkt_empty_reg  <= start ? in_pkt_empty : 6'd0;
                pkt_valid_reg  <= 1'b1;
                meta_valid_reg <= 1'b1;
            end else begin
                if (out_pkt_ready) begin
                    pkt_valid_reg <= 1'b0;
                end
                if (out_meta_ready) begin
                    meta_valid_reg <= 1'b0;
                end
            end

            if (emit_done) begin
                pkt_id_reg <= pkt_id_reg + PKT_ID_W'(1);
            end
        end
    end

    assign in_pkt_ready   = ready;
    assign out_pkt_data   = hdr_reg;
    assign out_pkt_valid  = pkt_valid_reg;
    assign out_pkt_sop    = pkt_valid_reg;
    assign out_pkt_eop    = pkt_valid_reg;
    assign out_pkt_empty  = pkt_empty_reg;
    assign out_meta_data  = meta_reg;
    assign out_meta_valid = meta_valid_reg;

endmodule
